dmem_ctrl: RTL and testbench

Parametrised data memory for the CPU load/store path, replacing the fixed 8×32 store with configurable width, depth and read latency. Adds a valid/ready request port, a pipelined load response, byte-enable stores, address-range checking and a reset-time initialisation sweep. It sits between the ALU address/RF store-data outputs and the RF write-back mux.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_rd_pipe.sv | 47 ++++
 rtl/dmem_ctrl.sv | 138 +++++++++++++
 tb/tb_dmem_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants, FSM state type and helpers for the dmem_ctrl data memory.
package dmem_pkg;

  localparam logic [5:0] OPC_LOAD  = 6'b000100;
  localparam logic [5:0] OPC_STORE = 6'b000101;

  typedef enum logic {INIT, IDLE} state_t;

  // Status bits travelling alongside load data through the read pipeline.
  typedef struct packed {
    logic valid;
    logic err;
  } rd_flags_t;

  function automatic logic [31:0] INIT_VALUE(input logic [31:0] i);
    return i + 32'd1;
  endfunction

endpackage

// File: rtl/dmem_rd_pipe.sv
// Delay line for load responses: STAGES registers carrying data, valid and err.
module dmem_rd_pipe
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STAGES = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  rd_flags_t         in_flags,
  output logic [DATA_W-1:0] out_data,
  output rd_flags_t         out_flags
);

  generate
    if (STAGES == 0) begin : g_bypass
      logic unused_ok;
      assign unused_ok = clock ^ reset;
      assign out_data  = in_data;
      assign out_flags = in_flags;
    end else begin : g_stages
      logic [DATA_W-1:0] data_q  [STAGES];
      rd_flags_t         flags_q [STAGES];

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < int'(STAGES); i++) begin
            data_q[i]  <= '0;
            flags_q[i] <= '0;
          end
        end else begin
          data_q[0]  <= in_data;
          flags_q[0] <= in_flags;
          for (int i = 1; i < int'(STAGES); i++) begin
            data_q[i]  <= data_q[i-1];
            flags_q[i] <= flags_q[i-1];
          end
        end
      end

      assign out_data  = data_q[STAGES-1];
      assign out_flags = flags_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/dmem_ctrl.sv
// Parametrised data memory with valid/ready requests, pipelined loads and reset-time init sweep.
// Optional macro DMEM_BYTE_WRITE_EN enables per-byte store lanes; otherwise stores write full words.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned READ_LAT = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [5:0]            OPC,
  input  logic [ADDR_W-1:0]     addressin,
  input  logic [DATA_W-1:0]     datain,
  input  logic [DATA_W/8-1:0]   byte_en,
  output logic [DATA_W-1:0]     dataout,
  output logic                  resp_valid,
  output logic                  addr_err,
  output logic                  busy
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned IDX_W = $clog2(DEPTH);
  // Wide enough that DEPTH itself is representable regardless of ADDR_W.
  localparam int unsigned CMP_W = (ADDR_W > 11) ? ADDR_W + 1 : 12;

  state_t              state;
  state_t              next_state;
  logic [IDX_W-1:0]    init_idx;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [CMP_W-1:0]    addr_ext;
  logic                in_range;
  logic [IDX_W-1:0]    addr_idx;
  logic                accept;
  logic                is_load;
  logic                is_store;
  logic [NB-1:0]       store_lanes;

  logic [NB-1:0]       mem_lanes;
  logic [IDX_W-1:0]    mem_idx;
  logic [DATA_W-1:0]   mem_wdata;

  logic [DATA_W-1:0]   rd_data_q;
  rd_flags_t           rd_flags_q;
  logic                st_err_q;
  logic [DATA_W-1:0]   pipe_data;
  rd_flags_t           pipe_flags;

  assign addr_ext = CMP_W'(addressin);
  assign in_range = addr_ext < CMP_W'(DEPTH);
  assign addr_idx = addr_ext[IDX_W-1:0];
  assign accept   = req_valid && req_ready;
  assign is_load  = accept && (OPC == OPC_LOAD);
  assign is_store = accept && (OPC == OPC_STORE);

`ifdef DMEM_BYTE_WRITE_EN
  assign store_lanes = byte_en;
`else
  logic unused_byte_en;
  assign unused_byte_en = ^byte_en;
  assign store_lanes    = '1;
`endif

  // Next state and the single array write port (init sweep or store).
  always_comb begin
    next_state = state;
    mem_lanes  = '0;
    mem_idx    = addr_idx;
    mem_wdata  = datain;
    case (state)
      INIT: begin
        mem_lanes = '1;
        mem_idx   = init_idx;
        mem_wdata = DATA_W'(INIT_VALUE(32'(init_idx)));
        if (init_idx == IDX_W'(DEPTH - 1)) next_state = IDLE;
      end
      IDLE: begin
        if (is_store && in_range) mem_lanes = store_lanes;
      end
      default: next_state = INIT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= INIT;
      init_idx  <= '0;
      busy      <= 1'b1;
      req_ready <= 1'b0;
    end else begin
      state     <= next_state;
      busy      <= (next_state == INIT);
      req_ready <= (next_state == IDLE);
      if (state == INIT)
        init_idx <= (init_idx == IDX_W'(DEPTH - 1)) ? '0 : init_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    for (int b = 0; b < int'(NB); b++)
      if (mem_lanes[b]) mem[mem_idx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
  end

  // First read stage: array is sampled at the accept edge; data holds between loads.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_flags_q <= '0;
      st_err_q   <= 1'b0;
    end else begin
      rd_flags_q.valid <= is_load;
      rd_flags_q.err   <= is_load && !in_range;
      st_err_q         <= is_store && !in_range;
      if (is_load) rd_data_q <= in_range ? mem[addr_idx] : '0;
    end
  end

  dmem_rd_pipe #(
    .DATA_W (DATA_W),
    .STAGES (READ_LAT - 1)
  ) u_rd_pipe (
    .clock     (clock),
    .reset     (reset),
    .in_data   (rd_data_q),
    .in_flags  (rd_flags_q),
    .out_data  (pipe_data),
    .out_flags (pipe_flags)
  );

  assign dataout    = pipe_data;
  assign resp_valid = pipe_flags.valid;
  assign addr_err   = pipe_flags.err | st_err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench: READ_LAT=1 and READ_LAT=3 instances share stimulus against a schedule model.
module tb_dmem_ctrl;

  localparam int DEPTH = 8;
  localparam int MAXC  = 4096;
  localparam logic [5:0] LD = 6'b000100;
  localparam logic [5:0] ST = 6'b000101;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [5:0]  opc = 6'd0;
  logic [31:0] addressin = '0;
  logic [31:0] datain = '0;
  logic [3:0]  byte_en = '0;

  logic [1:0]        req_ready, resp_valid, addr_err, busy;
  logic [1:0][31:0]  dataout;

  dmem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .READ_LAT(1)) u_lat1 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[0]),
    .OPC(opc), .addressin(addressin), .datain(datain), .byte_en(byte_en),
    .dataout(dataout[0]), .resp_valid(resp_valid[0]), .addr_err(addr_err[0]), .busy(busy[0]));

  dmem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .READ_LAT(3)) u_lat3 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[1]),
    .OPC(opc), .addressin(addressin), .datain(datain), .byte_en(byte_en),
    .dataout(dataout[1]), .resp_valid(resp_valid[1]), .addr_err(addr_err[1]), .busy(busy[1]));

  always #5 clock = ~clock;

`ifdef DMEM_BYTE_WRITE_EN
  localparam bit BYTE_MODE = 1'b1;
`else
  localparam bit BYTE_MODE = 1'b0;
`endif

  // Model: memory contents plus per-instance table of what each output shows in each cycle.
  int          cyc = 0;
  bit          in_reset = 1'b1;
  int          init_done = 1 << 30;
  logic [31:0] mem_m [DEPTH];
  bit          sched_v [2][MAXC];
  bit          sched_e [2][MAXC];
  logic [31:0] sched_d [2][MAXC];
  logic [31:0] exp_data [2];
  int          n_cmp = 0;
  int          n_fail = 0;

  logic [31:0] got_d0[$], got_d1[$];
  int          got_c0[$], got_c1[$];
  bit          got_e0[$];

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic check32(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'(i + 1);
    exp_data[0] = '0;
    exp_data[1] = '0;
  endtask

  task automatic model_apply(logic [5:0] o, logic [31:0] a, logic [31:0] dat, logic [3:0] be, int k);
    for (int d = 0; d < 2; d++) begin
      int t;
      t = k + lat_of(d) - 1;
      if (o == LD) begin
        sched_v[d][t] = 1'b1;
        if (a < DEPTH) sched_d[d][t] = mem_m[a[2:0]];
        else begin
          sched_d[d][t] = '0;
          sched_e[d][t] = 1'b1;
        end
      end else if (o == ST && a >= DEPTH) begin
        sched_e[d][k] = 1'b1;
      end
    end
    if (o == ST && a < DEPTH)
      for (int b = 0; b < 4; b++)
        if (be[b] || !BYTE_MODE) mem_m[a[2:0]][b*8 +: 8] = dat[b*8 +: 8];
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      bit ev;
      bit ee;
      bit eb;
      ev = 1'b0;
      ee = 1'b0;
      if (!in_reset && cyc < MAXC) begin
        ev = sched_v[d][cyc];
        ee = sched_e[d][cyc];
        if (ev) exp_data[d] = sched_d[d][cyc];
      end
      eb = in_reset || (cyc < init_done);
      check32($sformatf("resp_valid[lat%0d]", lat_of(d)), 32'(resp_valid[d]), 32'(ev));
      check32($sformatf("addr_err[lat%0d]", lat_of(d)), 32'(addr_err[d]), 32'(ee));
      check32($sformatf("dataout[lat%0d]", lat_of(d)), dataout[d], exp_data[d]);
      check32($sformatf("busy[lat%0d]", lat_of(d)), 32'(busy[d]), 32'(eb));
      check32($sformatf("req_ready[lat%0d]", lat_of(d)), 32'(req_ready[d]), 32'(!eb));
      if (resp_valid[d] === 1'b1) begin
        if (d == 0) begin
          got_d0.push_back(dataout[0]);
          got_c0.push_back(cyc);
          got_e0.push_back(addr_err[0]);
        end else begin
          got_d1.push_back(dataout[1]);
          got_c1.push_back(cyc);
        end
      end
    end
  end

  task automatic issue(logic [5:0] o, logic [31:0] a, logic [31:0] dat, logic [3:0] be, output int acc);
    int n;
    n = 0;
    @(negedge clock);
    while (cyc < init_done && n < 64) begin
      @(negedge clock);
      n++;
    end
    if (n >= 64) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ready_wait: got no ready within 64 cycles, expected ready");
    end
    req_valid = 1'b1;
    opc       = o;
    addressin = a;
    datain    = dat;
    byte_en   = be;
    @(posedge clock);
    #1;
    acc = cyc;
    model_apply(o, a, dat, be, cyc);
  endtask

  task automatic idle(int n);
    @(negedge clock);
    req_valid = 1'b0;
    opc       = 6'd0;
    repeat (n) @(negedge clock);
  endtask

  task automatic assert_reset();
    reset     = 1'b1;
    in_reset  = 1'b1;
    req_valid = 1'b0;
    init_done = 1 << 30;
    for (int d = 0; d < 2; d++)
      for (int i = cyc; i < MAXC; i++) begin
        sched_v[d][i] = 1'b0;
        sched_e[d][i] = 1'b0;
      end
    model_reset();
  endtask

  task automatic release_reset(int hold, output int r);
    repeat (hold) @(posedge clock);
    #1;
    reset     = 1'b0;
    in_reset  = 1'b0;
    init_done = cyc + DEPTH;
    r         = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int first_acc;
    int r;
    int n0;
    int n1;
    logic [31:0] bw_exp;
    model_reset();
    release_reset(3, r);

    // Request during the init sweep must be ignored.
    @(negedge clock);
    req_valid = 1'b1;
    opc       = LD;
    addressin = 32'd0;
    repeat (3) @(negedge clock);
    check32("busy_in_init", 32'(busy[0]), 32'd1);
    req_valid = 1'b0;

    // Initial contents sweep: addresses 0..7 back to back.
    first_acc = 0;
    for (int i = 0; i < DEPTH; i++) begin
      issue(LD, 32'(i), '0, '0, acc);
      if (i == 0) first_acc = acc;
    end
    idle(5);
    check32("first_accept_edge", 32'(first_acc), 32'(r + DEPTH + 1));
    check32("init_resp_count_lat1", 32'(got_d0.size()), 32'd8);
    check32("init_resp_count_lat3", 32'(got_d1.size()), 32'd8);
    for (int i = 0; i < DEPTH && i < got_d0.size() && i < got_d1.size(); i++) begin
      check32($sformatf("init_word_lat1_%0d", i), got_d0[i], 32'(i + 1));
      check32($sformatf("init_word_lat3_%0d", i), got_d1[i], 32'(i + 1));
    end
    if (got_c0.size() > 0 && got_c1.size() > 3) begin
      check32("lat1_first_resp_cycle", 32'(got_c0[0]), 32'(first_acc));
      check32("lat3_first_resp_cycle", 32'(got_c1[0]), 32'(first_acc + 2));
      check32("lat3_fourth_resp_cycle", 32'(got_c1[3]), 32'(first_acc + 5));
    end

    // Store then immediate load of the same word.
    n0 = got_d0.size();
    n1 = got_d1.size();
    issue(ST, 32'd3, 32'hDEADBEEF, 4'b1111, acc);
    issue(LD, 32'd3, '0, '0, acc);
    idle(5);
    check32("store_load_lat1", (got_d0.size() > n0) ? got_d0[n0] : 'x, 32'hDEADBEEF);
    check32("store_load_lat3", (got_d1.size() > n1) ? got_d1[n1] : 'x, 32'hDEADBEEF);

    // Partial byte-enable store.
    bw_exp = BYTE_MODE ? 32'h00BB00DD : 32'hAABBCCDD;
    n0 = got_d0.size();
    issue(ST, 32'd2, 32'hAABBCCDD, 4'b0101, acc);
    issue(LD, 32'd2, '0, '0, acc);
    idle(5);
    check32("byte_store", (got_d0.size() > n0) ? got_d0[n0] : 'x, bw_exp);

    // Out-of-range load just past the top, then out-of-range stores aliasing address 1.
    n0 = got_d0.size();
    issue(LD, 32'd8, '0, '0, acc);
    idle(5);
    check32("oor_load_data", (got_d0.size() > n0) ? got_d0[n0] : 'x, 32'd0);
    check32("oor_load_err", (got_e0.size() > n0) ? 32'(got_e0[n0]) : 'x, 32'd1);
    n0 = got_d0.size();
    issue(ST, 32'd9, 32'hFFFFFFFF, 4'b1111, acc);
    issue(ST, 32'h00000101, 32'h12345678, 4'b1111, acc);
    issue(LD, 32'd1, '0, '0, acc);
    issue(LD, 32'd7, '0, '0, acc);
    idle(5);
    check32("oor_store_no_write", (got_d0.size() > n0) ? got_d0[n0] : 'x, 32'd2);
    check32("top_word", (got_d0.size() > n0 + 1) ? got_d0[n0+1] : 'x, 32'd8);

    // Reset with two loads in flight; the array must be re-initialised.
    n0 = got_d0.size();
    n1 = got_d1.size();
    issue(LD, 32'd0, '0, '0, acc);
    issue(LD, 32'd1, '0, '0, acc);
    assert_reset();
    release_reset(2, r);
    @(negedge clock);
    check32("busy_after_reset", 32'(busy[1]), 32'd1);
    issue(LD, 32'd3, '0, '0, acc);
    issue(LD, 32'd2, '0, '0, acc);
    idle(6);
    check32("reset_resp_count_lat1", 32'(got_d0.size()), 32'(n0 + 3));
    check32("reset_resp_count_lat3", 32'(got_d1.size()), 32'(n1 + 2));
    if (got_d1.size() >= n1 + 2) begin
      check32("reinit_addr3", got_d1[n1], 32'd4);
      check32("reinit_addr2", got_d1[n1+1], 32'd3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
